// File: rtl/xrisc_muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The master side issues operands and accepts results; the slave side is the unit.
interface xrisc_muldiv_iter_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_funct3, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/xrisc_muldiv_iter.sv
// Radix-2 iterative RV32M multiply/divide: XLEN+1 cycles for normal ops, 1 cycle for
// divide-by-zero/overflow; result held in DONE until out_ready, flush aborts any state.
module xrisc_muldiv_iter #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   output logic               busy,
   xrisc_muldiv_iter_if.slave bus
);

   localparam int            CW       = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [2:0]       funct3_q;
   logic [TAG_W-1:0] tag_q;
   logic             neg_q;
   logic             sa_q;
   logic [XLEN-1:0]  opnd_q;
   logic [XLEN-1:0]  hi_q;
   logic [XLEN-1:0]  lo_q;
   logic [XLEN-1:0]  result_q;
   logic [CW-1:0]    cnt_q;

   logic             accept;
   logic             a_signed;
   logic             b_signed;
   logic             sa;
   logic             sb;
   logic             b_zero;
   logic             ovf;
   logic             special;
   logic [XLEN-1:0]  abs_a;
   logic [XLEN-1:0]  abs_b;
   logic [XLEN-1:0]  special_res;

   assign accept = bus.in_valid & (state == IDLE) & ~flush;

   // Operand decode at accept: signedness, magnitudes and the early-out results.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.in_funct3)
         F_MULH, F_DIV, F_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         F_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
      sa     = a_signed & bus.in_a[XLEN-1];
      sb     = b_signed & bus.in_b[XLEN-1];
      abs_a  = sa ? -bus.in_a : bus.in_a;
      abs_b  = sb ? -bus.in_b : bus.in_b;
      b_zero = (bus.in_b == '0);
      ovf    = b_signed & bus.in_funct3[2] & (bus.in_a == MIN_NEG) & (&bus.in_b);
      special = bus.in_funct3[2] & (b_zero | ovf);
      special_res = '0;
      if (b_zero) begin
         special_res = bus.in_funct3[1] ? bus.in_a : '1;
      end else if (ovf) begin
         special_res = bus.in_funct3[1] ? '0 : bus.in_a;
      end
   end

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;
   logic [XLEN-1:0] hi_step;
   logic [XLEN-1:0] lo_step;

   // One radix-2 step. Multiply: lo holds the multiplier and collects the low product
   // bits as {carry,hi,lo} shifts right. Divide: lo holds the dividend and collects quotient bits.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (funct3_q[2]) begin
         if (!div_diff[XLEN]) begin
            hi_step = div_diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_step = div_shift[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_step = mul_sum[XLEN:1];
         lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   fix_res;

   always_comb begin
      prod     = {hi_q, lo_q};
      prod_fix = neg_q ? -prod : prod;
      quot_fix = neg_q ? -lo_q : lo_q;
      rem_fix  = sa_q ? -hi_q : hi_q;
      case (funct3_q)
         F_MUL:                   fix_res = prod_fix[XLEN-1:0];
         F_MULH, F_MULHSU, F_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
         F_DIV, F_DIVU:           fix_res = quot_fix;
         default:                 fix_res = rem_fix;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt_q == CNT_LAST) begin
               state_n = FIX;
            end
         end
         FIX:  state_n = DONE;
         DONE: begin
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      if (flush) begin
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         funct3_q <= '0;
         tag_q    <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  funct3_q <= bus.in_funct3;
                  tag_q    <= bus.in_tag;
                  neg_q    <= sa ^ sb;
                  sa_q     <= sa;
                  opnd_q   <= bus.in_funct3[2] ? abs_b : abs_a;
                  hi_q     <= '0;
                  lo_q     <= bus.in_funct3[2] ? abs_a : abs_b;
                  cnt_q    <= '0;
                  if (special) begin
                     result_q <= special_res;
                  end
               end
            end
            CALC: begin
               hi_q  <= hi_step;
               lo_q  <= lo_step;
               cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            end
            FIX: result_q <= fix_res;
            default: ;
         endcase
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.out_result = result_q;
   assign bus.out_tag    = tag_q;
   assign busy           = (state != IDLE);

endmodule
